// File: rtl/board_mix_pkg.sv
// Shared types and constants for the N-layer compositor.
package board_mix_pkg;
    localparam int NUM_LAYERS_MAX = 4;
    localparam int ORDER_W = 2;
    localparam int CH_W = 5;
    localparam int OW = NUM_LAYERS_MAX * ORDER_W;

    // Slot k holds layer k: layer 0 front-most.
    localparam logic [OW-1:0] ORDER_RST = 8'hE4;

    typedef struct packed {
        logic [CH_W-1:0] b;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] r;
    } pal_entry_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_DONE
    } arb_state_e;
endpackage

// File: rtl/board_mix_n_if.sv
// CPU palette request/complete bundle.
interface board_mix_n_if #(
    parameter int PAL_AW = 8
) ();
    logic              PAL_REQ;
    logic              PAL_WE;
    logic [PAL_AW-1:0] PAL_A;
    logic [15:0]       PAL_DIN;
    logic [15:0]       PAL_DOUT;
    logic              PAL_ACK;

    modport master (
        output PAL_REQ, PAL_WE, PAL_A, PAL_DIN,
        input  PAL_DOUT, PAL_ACK
    );
    modport slave (
        input  PAL_REQ, PAL_WE, PAL_A, PAL_DIN,
        output PAL_DOUT, PAL_ACK
    );
endinterface

// File: rtl/board_mix_pal_ram.sv
// Single-port palette RAM, synchronous read; contents survive reset.
module board_mix_pal_ram
    import board_mix_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  pal_entry_t    wdata_i,
    output pal_entry_t    rdata_o
);
    pal_entry_t mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end
endmodule

// File: rtl/board_mix_n.sv
// N-layer priority compositor with double-buffered order/enable and palette.
// Optional grey bypass output under MIX_LAYER_BYPASS_EN.
module board_mix_n
    import board_mix_pkg::*;
#(
    parameter int         NUM_LAYERS = 3,
    parameter int         COL_W      = 4,
    parameter int         PAL_AW     = 8,
    parameter int         RGB_W      = 5,
    parameter logic [7:0] IO_BASE    = 8'h90
) (
    input  logic                        CLK_32M,
    input  logic                        RESET_N,
    input  logic                        CE_PIX,
    input  logic                        NL,
    input  logic [4*NUM_LAYERS-1:0]     BIT,
    input  logic [COL_W*NUM_LAYERS-1:0] COL,
    input  logic [NUM_LAYERS-1:0]       CP15,
    input  logic [NUM_LAYERS-1:0]       CP8,
    input  logic [7:0]                  IO_A,
    input  logic [7:0]                  IO_DIN,
    input  logic                        IOWR,
`ifdef MIX_LAYER_BYPASS_EN
    input  logic                        BYPASS,
`endif
    board_mix_n_if.slave                pal,
    output logic [RGB_W-1:0]            RED,
    output logic [RGB_W-1:0]            GREEN,
    output logic [RGB_W-1:0]            BLUE,
    output logic                        P1L
);
    logic [OW-1:0]         ord_sh_q, ord_act_q;
    logic [NUM_LAYERS-1:0] en_sh_q, en_act_q;

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            ord_sh_q  <= ORDER_RST;
            ord_act_q <= ORDER_RST;
            en_sh_q   <= '1;
            en_act_q  <= '1;
        end else begin
            if (IOWR && IO_A == IO_BASE) ord_sh_q <= IO_DIN;
            if (IOWR && IO_A == IO_BASE + 8'd1) en_sh_q <= IO_DIN[NUM_LAYERS-1:0];
            if (NL) begin
                ord_act_q <= ord_sh_q;
                en_act_q  <= en_sh_q;
            end
        end
    end

    // Pad to the maximum layer count so out-of-range order slots read as empty.
    logic [3:0]                lay_bit [NUM_LAYERS_MAX];
    logic [COL_W-1:0]          lay_col [NUM_LAYERS_MAX];
    logic [NUM_LAYERS_MAX-1:0] lay_en;
    logic [NUM_LAYERS-1:0]     opq, b3;

    for (genvar g = 0; g < NUM_LAYERS_MAX; g++) begin : g_lay
        if (g < NUM_LAYERS) begin : g_on
            assign lay_bit[g] = BIT[4*g +: 4];
            assign lay_col[g] = COL[COL_W*g +: COL_W];
            assign lay_en[g]  = en_act_q[g];
            assign opq[g]     = |BIT[4*g +: 4];
            assign b3[g]      = BIT[4*g+3];
        end else begin : g_off
            assign lay_bit[g] = '0;
            assign lay_col[g] = '0;
            assign lay_en[g]  = 1'b0;
        end
    end

    logic               win_found;
    logic [ORDER_W-1:0] win_idx, slot_idx;
    logic [3:0]         w_bit;
    logic [COL_W-1:0]   w_col;
    logic               p1l_d;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        slot_idx  = '0;
        for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
            slot_idx = ord_act_q[ORDER_W*s +: ORDER_W];
            if (lay_en[slot_idx] && lay_bit[slot_idx] != 4'd0) begin
                win_found = 1'b1;
                win_idx   = slot_idx;
            end
        end
    end

    assign w_bit = win_found ? lay_bit[win_idx] : 4'd0;
    assign w_col = lay_col[win_idx];
    assign p1l_d = ~|(CP15 & opq & en_act_q) & ~|(CP8 & b3 & en_act_q);

    arb_state_e        st_q;
    logic              armed_q, ack_q, we_q;
    logic [PAL_AW-1:0] a_q;
    pal_entry_t        din_q;
    logic [15:0]       dout_q;
    logic [PAL_AW-1:0] s0_addr_q;
    logic              s0_p1l_q, s1_p1l_q, s0_vld_q, s1_vld_q;
    logic              pix_rd_q;
    pal_entry_t        ram_rd, pix_hold_q, pix_ent, rgb_d;
    logic              cpu_op, unused_din;

    // The pixel fetch owns the RAM on CE_PIX cycles; the CPU gets the rest.
    assign cpu_op     = (st_q == ARB_ACCESS) && !CE_PIX;
    assign unused_din = pal.PAL_DIN[15];

    board_mix_pal_ram #(.AW(PAL_AW)) u_ram (
        .clk_i   (CLK_32M),
        .en_i    (CE_PIX | cpu_op),
        .we_i    (cpu_op & we_q),
        .addr_i  (CE_PIX ? s0_addr_q : a_q),
        .wdata_i (din_q),
        .rdata_o (ram_rd)
    );

    // A CPU read may overwrite the RAM output between pixel steps.
    assign pix_ent = pix_rd_q ? ram_rd : pix_hold_q;

`ifdef MIX_LAYER_BYPASS_EN
    logic [3:0] s0_bit_q, s1_bit_q;

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            s0_bit_q <= '0;
            s1_bit_q <= '0;
        end else if (CE_PIX) begin
            s0_bit_q <= w_bit;
            s1_bit_q <= s0_bit_q;
        end
    end

    always_comb begin
        rgb_d = pix_ent;
        if (BYPASS) begin
            rgb_d.r = {s1_bit_q, s1_bit_q[3]};
            rgb_d.g = {s1_bit_q, s1_bit_q[3]};
            rgb_d.b = {s1_bit_q, s1_bit_q[3]};
        end
    end
`else
    assign rgb_d = pix_ent;
`endif

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            s0_addr_q  <= '0;
            s0_p1l_q   <= 1'b1;
            s1_p1l_q   <= 1'b1;
            s0_vld_q   <= 1'b0;
            s1_vld_q   <= 1'b0;
            pix_rd_q   <= 1'b0;
            pix_hold_q <= '0;
            RED        <= '0;
            GREEN      <= '0;
            BLUE       <= '0;
            P1L        <= 1'b1;
        end else begin
            pix_rd_q <= CE_PIX;
            if (pix_rd_q) pix_hold_q <= ram_rd;
            if (CE_PIX) begin
                s0_addr_q <= win_found ? {w_col, w_bit} : '0;
                s0_p1l_q  <= p1l_d;
                s0_vld_q  <= 1'b1;
                s1_p1l_q  <= s0_p1l_q;
                s1_vld_q  <= s0_vld_q;
                if (s1_vld_q) begin
                    RED   <= rgb_d.r;
                    GREEN <= rgb_d.g;
                    BLUE  <= rgb_d.b;
                    P1L   <= s1_p1l_q;
                end
            end
        end
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q    <= ARB_IDLE;
            armed_q <= 1'b1;
            ack_q   <= 1'b0;
            we_q    <= 1'b0;
            a_q     <= '0;
            din_q   <= '0;
            dout_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            if (!pal.PAL_REQ) armed_q <= 1'b1;
            unique case (st_q)
                ARB_IDLE: begin
                    if (pal.PAL_REQ && armed_q && !CE_PIX) begin
                        st_q    <= ARB_ACCESS;
                        armed_q <= 1'b0;
                        we_q    <= pal.PAL_WE;
                        a_q     <= pal.PAL_A;
                        din_q   <= pal.PAL_DIN[14:0];
                    end
                end
                ARB_ACCESS: begin
                    if (!CE_PIX) st_q <= ARB_DONE;
                end
                ARB_DONE: begin
                    st_q  <= ARB_IDLE;
                    ack_q <= 1'b1;
                    if (!we_q) dout_q <= {1'b0, ram_rd};
                end
                default: st_q <= ARB_IDLE;
            endcase
        end
    end

    assign pal.PAL_ACK  = ack_q;
    assign pal.PAL_DOUT = dout_q;
endmodule

// File: tb/tb_board_mix_n.sv
// Directed bench for board_mix_n: layer priority, order/enable buffering,
// priority taps, palette handshake and reset abort.
`timescale 1ns/1ps
module tb_board_mix_n;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce = 1'b0;
    logic        nl = 1'b0;
    logic        iowr = 1'b0;
    logic [11:0] bitv = '0;
    logic [11:0] col = '0;
    logic [2:0]  cp15 = '0;
    logic [2:0]  cp8 = '0;
    logic [7:0]  io_a = '0;
    logic [7:0]  io_din = '0;
    logic [4:0]  red, green, blue;
    logic        p1l;
    logic        ackseen;
    int          nchk = 0;
    int          nerr = 0;
    int          ph = 0;

    board_mix_n_if #(.PAL_AW(8)) pal ();

    always #5 clk = ~clk;

    board_mix_n dut (
        .CLK_32M (clk),
        .RESET_N (rst_n),
        .CE_PIX  (ce),
        .NL      (nl),
        .BIT     (bitv),
        .COL     (col),
        .CP15    (cp15),
        .CP8     (cp8),
        .IO_A    (io_a),
        .IO_DIN  (io_din),
        .IOWR    (iowr),
`ifdef MIX_LAYER_BYPASS_EN
        .BYPASS  (1'b0),
`endif
        .pal     (pal),
        .RED     (red),
        .GREEN   (green),
        .BLUE    (blue),
        .P1L     (p1l)
    );

    function automatic logic [14:0] rgb(input int r, input int g, input int b);
        return {5'(r), 5'(g), 5'(b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int n);
        for (int i = 0; i < n; i++) begin
            ce = 1'b1;
            tick();
            ce = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        io_a = a;
        io_din = d;
        iowr = 1'b1;
        tick();
        iowr = 1'b0;
    endtask

    task automatic nl_pulse();
        nl = 1'b1;
        tick();
        nl = 1'b0;
    endtask

    // Runs CE_PIX at 1/4 rate while waiting so the arbiter has to yield.
    task automatic pal_op(input logic we, input logic [7:0] a, input logic [15:0] d);
        int n;
        logic got;
        pal.PAL_REQ = 1'b1;
        pal.PAL_WE  = we;
        pal.PAL_A   = a;
        pal.PAL_DIN = d;
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            ce = (ph == 0);
            ph = (ph + 1) % 4;
            tick();
            n++;
            got = pal.PAL_ACK;
        end
        ce = 1'b0;
        chk("pal_ack_within_4", {31'd0, got && n <= 4}, 32'd1);
        pal.PAL_REQ = 1'b0;
        tick();
    endtask

    initial begin
        pal.PAL_REQ = 1'b0;
        pal.PAL_WE  = 1'b0;
        pal.PAL_A   = '0;
        pal.PAL_DIN = '0;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_rgb", {red, green, blue}, 0);
        chk("rst_p1l", p1l, 1);
        chk("rst_ack", pal.PAL_ACK, 0);
        chk("rst_dout", pal.PAL_DOUT, 0);
        rst_n = 1'b1;
        tick();

        pal_op(1'b1, 8'h00, 16'h0421);
        pal_op(1'b1, 8'h13, 16'h0C41);
        pal_op(1'b1, 8'h25, 16'h18A4);
        pal_op(1'b0, 8'h13, 16'h0000);
        chk("rd_13", pal.PAL_DOUT, 16'h0C41);

        bitv = 12'h053;
        col  = 12'h321;
        pix(3);
        chk("l0_front", {red, green, blue}, rgb(1, 2, 3));
        chk("l0_p1l", p1l, 1);

        io_wr(8'h90, 8'hE1);
        pix(3);
        chk("order_pending", {red, green, blue}, rgb(1, 2, 3));
        nl_pulse();
        pix(3);
        chk("order_active", {red, green, blue}, rgb(4, 5, 6));

        io_a = 8'h90;
        io_din = 8'hE4;
        iowr = 1'b1;
        nl = 1'b1;
        tick();
        iowr = 1'b0;
        nl = 1'b0;
        pix(3);
        chk("iowr_with_nl_old", {red, green, blue}, rgb(4, 5, 6));
        nl_pulse();
        pix(3);
        chk("iowr_with_nl_new", {red, green, blue}, rgb(1, 2, 3));

        bitv = 12'h000;
        pix(3);
        chk("all_clear_rgb", {red, green, blue}, rgb(1, 1, 1));
        chk("all_clear_p1l", p1l, 1);

        bitv = 12'h053;
        cp15 = 3'b111;
        io_wr(8'h91, 8'h00);
        nl_pulse();
        pix(3);
        chk("en_off_rgb", {red, green, blue}, rgb(1, 1, 1));
        chk("en_off_p1l", p1l, 1);

        cp15 = 3'b000;
        io_wr(8'h91, 8'h07);
        nl_pulse();
        cp8 = 3'b100;
        bitv = 12'h953;
        pix(3);
        chk("cp8_bit3_p1l", p1l, 0);
        chk("cp8_bit3_rgb", {red, green, blue}, rgb(1, 2, 3));
        bitv = 12'h153;
        pix(3);
        chk("cp8_nobit3_p1l", p1l, 1);
        cp8 = 3'b000;
        cp15 = 3'b010;
        pix(3);
        chk("cp15_l1_p1l", p1l, 0);
        cp15 = 3'b100;
        io_wr(8'h91, 8'h03);
        nl_pulse();
        pix(3);
        chk("cp15_l2_off_p1l", p1l, 1);
        cp15 = 3'b000;
        io_wr(8'h91, 8'h07);
        nl_pulse();

        pal_op(1'b1, 8'h25, 16'h7FFF);
        pal_op(1'b0, 8'h25, 16'h0000);
        chk("rd_25", pal.PAL_DOUT, 16'h7FFF);
        io_wr(8'h90, 8'hE1);
        nl_pulse();
        bitv = 12'h053;
        pix(3);
        chk("white_pixel", {red, green, blue}, rgb(31, 31, 31));

        ce = 1'b0;
        pal.PAL_REQ = 1'b1;
        pal.PAL_WE  = 1'b1;
        pal.PAL_A   = 8'h13;
        pal.PAL_DIN = 16'h7FFF;
        tick();
        rst_n = 1'b0;
        ackseen = 1'b0;
        repeat (4) begin
            tick();
            if (pal.PAL_ACK) ackseen = 1'b1;
        end
        chk("abort_no_ack", ackseen, 0);
        chk("abort_rgb", {red, green, blue}, 0);
        chk("abort_p1l", p1l, 1);
        chk("abort_dout", pal.PAL_DOUT, 0);
        pal.PAL_REQ = 1'b0;
        rst_n = 1'b1;
        tick();
        pix(2);
        chk("latency_2ce", {red, green, blue}, 0);
        pix(1);
        chk("latency_3ce_identity", {red, green, blue}, rgb(1, 2, 3));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d checks done", nchk);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/board_mix_n.md
Name: board_mix_n

Overview:
- Parametrised N-layer pixel compositor and palette stage for the M72-family video path; successor to the fixed two-layer B-D mixer.
- Takes per-layer 4-bit pixel, colour and priority-tap signals, resolves the front-most opaque layer using a double-buffered, CPU-programmable layer order, and looks up RGB in an internal single-port palette RAM.
- The CPU reaches the palette RAM through a request/complete handshake that is arbitrated around pixel fetches.

Parameters:
- NUM_LAYERS, 3, tile layers mixed; 2..4.
- COL_W, 4, colour/bank bits per layer.
- PAL_AW, 8, palette address width; must equal COL_W+4.
- RGB_W, 5, bits per colour channel.
- IO_BASE, 8'h90, IO address of the ORDER register; ENABLE register is at IO_BASE+1.

Ports:
- CLK_32M  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- CE_PIX  in  1  pixel clock enable.
- NL  in  1  new-line strobe, one cycle.
- BIT  in  4*NUM_LAYERS  pixel index per layer; layer i occupies [4i+3:4i].
- COL  in  COL_W*NUM_LAYERS  colour bank per layer.
- CP15  in  NUM_LAYERS  per-layer priority tap, any opaque pixel.
- CP8  in  NUM_LAYERS  per-layer priority tap, BIT[3] only.
- IO_A  in  8  IO address.
- IO_DIN  in  8  IO write data.
- IOWR  in  1  IO write strobe.
- PAL_REQ  in  1  CPU palette access request; level signal, held until PAL_ACK.
- PAL_WE  in  1  1 = write, 0 = read.
- PAL_A  in  PAL_AW  palette entry address.
- PAL_DIN  in  16  {1'b0, B, G, R} for a write.
- PAL_DOUT  out  16  read data.
- PAL_ACK  out  1  one-cycle completion pulse.
- RED / GREEN / BLUE  out  RGB_W  pixel output.
- P1L  out  1  active-low "tile in front of sprites" flag.

Behaviour:
- Reset state: RGB=0, P1L=1, PAL_ACK=0, PAL_DOUT=0. ORDER shadow and ORDER active both = identity (layer 0 front-most). ENABLE shadow and ENABLE active both = all ones. Pipeline valid bits cleared.
- IO writes:
  - IOWR at IO_BASE writes the ORDER shadow: 2-bit layer index per slot, slot 0 = front.
  - IOWR at IO_BASE+1 writes the ENABLE shadow, using bits [NUM_LAYERS-1:0].
  - On NL both shadows copy to active. An IOWR in the same cycle as NL: the new value lands in shadow only and takes effect at the next NL.
  - An ORDER slot holding an index >= NUM_LAYERS is treated as empty.
- Pipeline (advances only on CE_PIX; latency 3 CE_PIX):
  - S0: winner = first slot whose layer is enabled and has BIT != 0. Register palette address {COL, BIT} of the winner. If no layer qualifies, register address 0 and set the transparent flag.
  - S1: palette RAM read on the CE_PIX cycle.
  - S2: register RGB. The transparent flag forces RGB = entry 0 (backdrop).
- P1L = ~|(CP15 & opaque & en) & ~|(CP8 & BIT[3] & en), registered on CE_PIX and aligned to the S2 output.
- Palette arbiter FSM: IDLE -> ACCESS -> DONE -> IDLE.
  - IDLE to ACCESS when PAL_REQ=1 and CE_PIX=0; the pixel read always wins a CE_PIX cycle.
  - ACCESS performs the RAM write or read.
  - DONE pulses PAL_ACK and presents PAL_DOUT (held until the next read).
  - A new request is accepted only after PAL_REQ drops for at least one cycle.
  - Worst-case completion is 4 cycles with CE_PIX at 1/4 rate.
- RESET_N asserted mid-access aborts the access with no ACK. RAM contents are not cleared.

Optional Feature:
- Macro: MIX_LAYER_BYPASS_EN.
- Defined: adds input port BYPASS. When BYPASS=1, S2 outputs grey {BIT_w, BIT_w[3]} on all three channels, where BIT_w is the winner's pixel index; the palette is ignored. CPU palette access is unaffected.
- Not defined: no BYPASS port; palette output only.

Decomposition:
- Package board_mix_pkg: NUM_LAYERS_MAX=4, ORDER_W=2, pal_entry_t {b,g,r}, arbiter state enum, reset ORDER constant.
- Sub-module board_mix_pal_ram: single-port PAL_AW x 15 RAM with synchronous read.

Test Plan:
- Reset, then layers 0..2 with BIT=3,5,0, COL=1,2,3, identity ORDER -> after 3 CE_PIX the output is palette[0x13].
- Write ORDER = {2,0,1} with IOWR mid-line -> old winner kept until NL; after NL layer 1 (BIT=5) is shown -> palette[0x25].
- All BIT=0, or ENABLE=0 -> RGB = entry 0 and P1L=1.
- CP8 on layer 2 with BIT=4'h9 and layer 2 enabled -> P1L=0 after 3 CE_PIX; with BIT=4'h1 -> P1L=1.
- Palette write to 0x25 = 16'h7FFF, then read back -> PAL_ACK within 4 cycles, PAL_DOUT=16'h7FFF; the next pixel using 0x25 outputs 31/31/31.
- Assert RESET_N during the ACCESS state -> no PAL_ACK, outputs return to reset values, ORDER back to identity.
